udp_cmd_dispatch: RTL and testbench
===================================

UDP_CMD_DISPATCH -- requirements
Module: udp_cmd_dispatch

Interface
REQ-001 SHALL have parameter CMD_TO_CLKS, default 16, meaning the local command-bus ack timeout in clocks.
REQ-002 SHALL have parameter MIB_TO_CLKS, default 32, meaning the MIB ack timeout in clocks.
REQ-003 SHALL have port i_sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_sys_arst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have request ports, all inputs except o_req_ready:
- i_req_valid (1)
- o_req_ready (1), output
- i_req_seq (32): sequence number
- i_req_msg_id (8)
- i_req_addr (32)
- i_req_data (32): write data
REQ-006 SHALL have command-bus ports:
- o_cmd_sel (1), o_cmd_rd_wr_n (1), o_cmd_addr (20), o_cmd_wr_data (32): outputs
- i_cmd_ack (1), i_cmd_rd_data (32): inputs
REQ-007 SHALL have MIB ports:
- o_mib_start (1), o_mib_rd_wr_n (1), o_mib_addr (24), o_mib_wr_data (32): outputs
- i_mib_ack (1), i_mib_rd_data (32): inputs
REQ-008 SHALL have response ports:
- o_rsp_valid (1), o_rsp_seq (32), o_rsp_msg_id (8), o_rsp_data (32): outputs
- i_rsp_ready (1): input
REQ-009 SHALL have port o_timeout_cnt, output, 16 bits: saturating count of ack timeouts.

Function
REQ-010 SHALL implement states IDLE, DECODE, CMD_WAIT, MIB_WAIT and RESP; one request is in flight at a time.
REQ-011 SHALL assert o_req_ready only in IDLE; a request transfers on the cycle where valid and ready are both high, capturing all request fields, and the state moves to DECODE.
REQ-012 SHALL decode in DECODE, one cycle, with sel = addr[25:24] and addr[31:26] ignored.
REQ-013 SHALL treat a transaction as a write if msg_id is 0x00 and as a read if msg_id is 0x01.
REQ-014 SHALL, for any other msg_id, go to RESP with rsp_msg_id 0xFF and rsp_data 0.
REQ-015 SHALL, for sel 2'b00, drive these for exactly one cycle on the DECODE->CMD_WAIT transition, then go to CMD_WAIT:
- o_cmd_sel = 1
- o_cmd_addr = addr[19:0]
- o_cmd_rd_wr_n = 1 for read
- o_cmd_wr_data = captured data
REQ-016 SHALL, for sel 2'b01, pulse o_mib_start for one cycle with o_mib_addr = addr[23:0] and the same rd_wr_n and data rules as REQ-015, then go to MIB_WAIT.
REQ-017 SHALL, for sel 2'b10 or 2'b11, go to RESP with rsp_msg_id 0xF1 and rsp_data 0.
REQ-018 SHALL hold o_cmd_addr, o_mib_addr, rd_wr_n and wr_data stable from launch until the WAIT state exits.
REQ-019 SHALL clear a wait counter at launch and, in each WAIT state, increment it every cycle.
REQ-020 SHALL, on ack in a WAIT state, go to RESP with rsp_msg_id 0xF0 and rsp_data set to the bus rd_data for a read or 0 for a write.
REQ-021 SHALL, when no ack has arrived and the wait counter reaches CMD_TO_CLKS (CMD_WAIT) or MIB_TO_CLKS (MIB_WAIT), go to RESP with rsp_msg_id 0xF1 and rsp_data 0, and increment o_timeout_cnt.
REQ-022 SHALL saturate o_timeout_cnt at 0xFFFF.
REQ-023 SHALL give priority to ack when ack and timeout occur in the same cycle, with no increment of o_timeout_cnt.
REQ-024 SHALL ignore i_cmd_ack and i_mib_ack outside their own WAIT state, including late acks that arrive after a timeout.
REQ-025 SHALL assert o_rsp_valid in RESP with o_rsp_seq equal to the captured seq, and hold all response fields stable until i_rsp_ready is high.
REQ-026 SHALL return to IDLE on the cycle after the response handshake; back-to-back requests are not pipelined.
REQ-027 SHALL give a latency for a write ack returned the cycle after launch of 4 cycles from request handshake to o_rsp_valid: capture, DECODE, launch/WAIT, RESP.

Reset
REQ-028 SHALL, while i_sys_arst_n is low, immediately force:
- state to IDLE
- o_req_ready, o_cmd_sel, o_mib_start and o_rsp_valid to 0
- all address, data, seq and msg_id outputs to 0
- o_timeout_cnt and the wait counter to 0
REQ-029 SHALL abandon any in-flight transaction on reset mid-operation with no response; the first cycle after reset release is IDLE with o_req_ready = 1.

Verification
REQ-030 SHALL cover these directed scenarios:
- Write msg 0x00, addr 0x0001_0004, data 0xDEADBEEF -> one-cycle o_cmd_sel, cmd_addr 0x10004, rd_wr_n 0; ack after 3 cycles -> rsp seq echoed, msg 0xF0, data 0.
- Read msg 0x01, addr 0x0135_0010, MIB ack with rd_data 0x12345678 -> o_mib_addr 0x350010, rsp 0xF0 / 0x12345678.
- Read to MIB, no ack -> rsp 0xF1 exactly MIB_TO_CLKS cycles after launch; o_timeout_cnt = 1; a late ack is ignored.
- msg_id 0x07 -> rsp 0xFF, no bus activity; addr sel 2'b10 -> rsp 0xF1, no bus activity.
- i_rsp_ready held low 10 cycles -> response stable and o_req_ready stays 0; reset asserted during CMD_WAIT -> all outputs 0, IDLE on release.
- Ack and timeout in the same cycle -> 0xF0 and o_timeout_cnt unchanged; 65536 forced timeouts -> counter saturates at 0xFFFF.

Source files
------------

// File: rtl/udp_cmd_dispatch_if.sv
// Request, command-bus, MIB and response signals of udp_cmd_dispatch.
// The slave modport is the dispatcher; master is the surrounding logic.
interface udp_cmd_dispatch_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_seq;
    logic [7:0]  i_req_msg_id;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_data;

    logic        o_cmd_sel;
    logic        o_cmd_rd_wr_n;
    logic [19:0] o_cmd_addr;
    logic [31:0] o_cmd_wr_data;
    logic        i_cmd_ack;
    logic [31:0] i_cmd_rd_data;

    logic        o_mib_start;
    logic        o_mib_rd_wr_n;
    logic [23:0] o_mib_addr;
    logic [31:0] o_mib_wr_data;
    logic        i_mib_ack;
    logic [31:0] i_mib_rd_data;

    logic        o_rsp_valid;
    logic [31:0] o_rsp_seq;
    logic [7:0]  o_rsp_msg_id;
    logic [31:0] o_rsp_data;
    logic        i_rsp_ready;

    logic [15:0] o_timeout_cnt;

    modport slave (
        input  i_req_valid, i_req_seq, i_req_msg_id, i_req_addr, i_req_data,
        output o_req_ready,
        output o_cmd_sel, o_cmd_rd_wr_n, o_cmd_addr, o_cmd_wr_data,
        input  i_cmd_ack, i_cmd_rd_data,
        output o_mib_start, o_mib_rd_wr_n, o_mib_addr, o_mib_wr_data,
        input  i_mib_ack, i_mib_rd_data,
        output o_rsp_valid, o_rsp_seq, o_rsp_msg_id, o_rsp_data,
        input  i_rsp_ready,
        output o_timeout_cnt
    );

    modport master (
        output i_req_valid, i_req_seq, i_req_msg_id, i_req_addr, i_req_data,
        input  o_req_ready,
        input  o_cmd_sel, o_cmd_rd_wr_n, o_cmd_addr, o_cmd_wr_data,
        output i_cmd_ack, i_cmd_rd_data,
        input  o_mib_start, o_mib_rd_wr_n, o_mib_addr, o_mib_wr_data,
        output i_mib_ack, i_mib_rd_data,
        input  o_rsp_valid, o_rsp_seq, o_rsp_msg_id, o_rsp_data,
        output i_rsp_ready,
        input  o_timeout_cnt
    );
endinterface

// File: rtl/udp_cmd_dispatch.sv
// UDP command dispatcher: one request at a time, routed to the local
// command bus or the MIB, with ack timeouts and a saturating error count.
module udp_cmd_dispatch #(
    parameter int CMD_TO_CLKS = 16,
    parameter int MIB_TO_CLKS = 32
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_arst_n,
    udp_cmd_dispatch_if.slave bus
);
    localparam logic [15:0] CMD_TO  = 16'(CMD_TO_CLKS);
    localparam logic [15:0] MIB_TO  = 16'(MIB_TO_CLKS);
    localparam logic [7:0]  MSG_WR  = 8'h00;
    localparam logic [7:0]  MSG_RD  = 8'h01;
    localparam logic [7:0]  RSP_OK  = 8'hF0;
    localparam logic [7:0]  RSP_ERR = 8'hF1;
    localparam logic [7:0]  RSP_BAD = 8'hFF;

    typedef enum logic [2:0] {
        IDLE, DECODE, CMD_WAIT, MIB_WAIT, RESP
    } state_t;

    state_t      state;
    logic        req_ready;
    logic [31:0] seq_q;
    logic [7:0]  msg_q;
    logic [25:0] addr_q;
    logic [31:0] data_q;
    logic        cmd_sel;
    logic        cmd_rd_wr_n;
    logic [19:0] cmd_addr;
    logic [31:0] cmd_wr_data;
    logic        mib_start;
    logic        mib_rd_wr_n;
    logic [23:0] mib_addr;
    logic [31:0] mib_wr_data;
    logic        rsp_valid;
    logic [31:0] rsp_seq;
    logic [7:0]  rsp_msg_id;
    logic [31:0] rsp_data;
    logic [15:0] wait_cnt;
    logic [15:0] timeout_cnt;

    logic        is_rd;
    logic        msg_ok;
    logic        go_cmd;
    logic        go_mib;
    logic [15:0] wait_nxt;
    logic [15:0] to_inc;

    assign is_rd    = (msg_q == MSG_RD);
    assign msg_ok   = (msg_q == MSG_WR) || is_rd;
    assign go_cmd   = msg_ok && (addr_q[25:24] == 2'b00);
    assign go_mib   = msg_ok && (addr_q[25:24] == 2'b01);
    assign wait_nxt = wait_cnt + 16'd1;
    assign to_inc   = (timeout_cnt == 16'hFFFF) ? timeout_cnt
                                                : timeout_cnt + 16'd1;

    assign bus.o_req_ready   = req_ready;
    assign bus.o_cmd_sel     = cmd_sel;
    assign bus.o_cmd_rd_wr_n = cmd_rd_wr_n;
    assign bus.o_cmd_addr    = cmd_addr;
    assign bus.o_cmd_wr_data = cmd_wr_data;
    assign bus.o_mib_start   = mib_start;
    assign bus.o_mib_rd_wr_n = mib_rd_wr_n;
    assign bus.o_mib_addr    = mib_addr;
    assign bus.o_mib_wr_data = mib_wr_data;
    assign bus.o_rsp_valid   = rsp_valid;
    assign bus.o_rsp_seq     = rsp_seq;
    assign bus.o_rsp_msg_id  = rsp_msg_id;
    assign bus.o_rsp_data    = rsp_data;
    assign bus.o_timeout_cnt = timeout_cnt;

    // Dispatch FSM; every output is a register updated here.
    always_ff @(posedge i_sys_clk or negedge i_sys_arst_n) begin
        if (!i_sys_arst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            seq_q       <= '0;
            msg_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cmd_sel     <= 1'b0;
            cmd_rd_wr_n <= 1'b0;
            cmd_addr    <= '0;
            cmd_wr_data <= '0;
            mib_start   <= 1'b0;
            mib_rd_wr_n <= 1'b0;
            mib_addr    <= '0;
            mib_wr_data <= '0;
            rsp_valid   <= 1'b0;
            rsp_seq     <= '0;
            rsp_msg_id  <= '0;
            rsp_data    <= '0;
            wait_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            cmd_sel   <= 1'b0;
            mib_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_ready && bus.i_req_valid) begin
                        req_ready <= 1'b0;
                        seq_q     <= bus.i_req_seq;
                        msg_q     <= bus.i_req_msg_id;
                        addr_q    <= bus.i_req_addr[25:0];
                        data_q    <= bus.i_req_data;
                        state     <= DECODE;
                    end
                end
                DECODE: begin
                    wait_cnt <= '0;
                    unique case (1'b1)
                        go_cmd: begin
                            cmd_sel     <= 1'b1;
                            cmd_rd_wr_n <= is_rd;
                            cmd_addr    <= addr_q[19:0];
                            cmd_wr_data <= data_q;
                            state       <= CMD_WAIT;
                        end
                        go_mib: begin
                            mib_start   <= 1'b1;
                            mib_rd_wr_n <= is_rd;
                            mib_addr    <= addr_q[23:0];
                            mib_wr_data <= data_q;
                            state       <= MIB_WAIT;
                        end
                        default: begin
                            rsp_valid  <= 1'b1;
                            rsp_seq    <= seq_q;
                            rsp_msg_id <= msg_ok ? RSP_ERR : RSP_BAD;
                            rsp_data   <= '0;
                            state      <= RESP;
                        end
                    endcase
                end
                CMD_WAIT: begin
                    wait_cnt <= wait_nxt;
                    if (bus.i_cmd_ack) begin
                        rsp_valid  <= 1'b1;
                        rsp_seq    <= seq_q;
                        rsp_msg_id <= RSP_OK;
                        rsp_data   <= is_rd ? bus.i_cmd_rd_data : '0;
                        state      <= RESP;
                    end else if (wait_nxt == CMD_TO) begin
                        rsp_valid   <= 1'b1;
                        rsp_seq     <= seq_q;
                        rsp_msg_id  <= RSP_ERR;
                        rsp_data    <= '0;
                        timeout_cnt <= to_inc;
                        state       <= RESP;
                    end
                end
                MIB_WAIT: begin
                    wait_cnt <= wait_nxt;
                    if (bus.i_mib_ack) begin
                        rsp_valid  <= 1'b1;
                        rsp_seq    <= seq_q;
                        rsp_msg_id <= RSP_OK;
                        rsp_data   <= is_rd ? bus.i_mib_rd_data : '0;
                        state      <= RESP;
                    end else if (wait_nxt == MIB_TO) begin
                        rsp_valid   <= 1'b1;
                        rsp_seq     <= seq_q;
                        rsp_msg_id  <= RSP_ERR;
                        rsp_data    <= '0;
                        timeout_cnt <= to_inc;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_cmd_dispatch.sv
// Directed bench for udp_cmd_dispatch: inputs driven and outputs
// sampled on the falling clock edge, expectations written by hand.
module tb_udp_cmd_dispatch;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    udp_cmd_dispatch_if bus ();

    udp_cmd_dispatch #(
        .CMD_TO_CLKS(16),
        .MIB_TO_CLKS(32)
    ) dut (
        .i_sys_clk   (clk),
        .i_sys_arst_n(rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] seq, input logic [7:0] msg,
                        input logic [31:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        while (bus.o_req_ready !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        if (n == 20)
            chk("req_ready_wait", 32'(bus.o_req_ready), 32'd1);
        bus.i_req_valid  = 1'b1;
        bus.i_req_seq    = seq;
        bus.i_req_msg_id = msg;
        bus.i_req_addr   = addr;
        bus.i_req_data   = data;
        tick(1);
        bus.i_req_valid  = 1'b0;
    endtask

    logic        ok;
    logic [15:0] exp_sat [3];

    initial begin
        exp_sat[0] = 16'hFFFE;
        exp_sat[1] = 16'hFFFF;
        exp_sat[2] = 16'hFFFF;
        rst_n             = 1'b0;
        bus.i_req_valid   = 1'b0;
        bus.i_req_seq     = '0;
        bus.i_req_msg_id  = '0;
        bus.i_req_addr    = '0;
        bus.i_req_data    = '0;
        bus.i_cmd_ack     = 1'b0;
        bus.i_cmd_rd_data = '0;
        bus.i_mib_ack     = 1'b0;
        bus.i_mib_rd_data = '0;
        bus.i_rsp_ready   = 1'b1;

        tick(1);
        chk("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("rst_timeout", 32'(bus.o_timeout_cnt), 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_ready", 32'(bus.o_req_ready), 32'd1);

        // write to command bus, ack three cycles into the wait
        send(32'd1, 8'h00, 32'h0001_0004, 32'hDEADBEEF);
        tick(1);
        chk("wr_cmd_sel", 32'(bus.o_cmd_sel), 32'd1);
        chk("wr_cmd_addr", 32'(bus.o_cmd_addr), 32'h10004);
        chk("wr_cmd_rdwr", 32'(bus.o_cmd_rd_wr_n), 32'd0);
        chk("wr_cmd_data", bus.o_cmd_wr_data, 32'hDEADBEEF);
        chk("wr_no_mib", 32'(bus.o_mib_start), 32'd0);
        tick(1);
        chk("wr_sel_pulse", 32'(bus.o_cmd_sel), 32'd0);
        chk("wr_addr_hold", 32'(bus.o_cmd_addr), 32'h10004);
        tick(2);
        chk("wr_no_rsp_yet", 32'(bus.o_rsp_valid), 32'd0);
        chk("wr_data_hold", bus.o_cmd_wr_data, 32'hDEADBEEF);
        bus.i_cmd_ack = 1'b1;
        tick(1);
        bus.i_cmd_ack = 1'b0;
        chk("wr_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
        chk("wr_rsp_seq", bus.o_rsp_seq, 32'd1);
        chk("wr_rsp_msg", 32'(bus.o_rsp_msg_id), 32'hF0);
        chk("wr_rsp_data", bus.o_rsp_data, 32'd0);
        tick(1);
        chk("wr_done_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("wr_done_ready", 32'(bus.o_req_ready), 32'd1);

        // minimum latency: ack in the launch cycle
        send(32'd2, 8'h00, 32'h0000_0020, 32'h11);
        tick(1);
        chk("lat_launch_novalid", 32'(bus.o_rsp_valid), 32'd0);
        bus.i_cmd_ack = 1'b1;
        tick(1);
        bus.i_cmd_ack = 1'b0;
        chk("lat_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
        chk("lat_rsp_msg", 32'(bus.o_rsp_msg_id), 32'hF0);
        tick(1);

        // read via MIB
        send(32'd3, 8'h01, 32'h0135_0010, 32'h0);
        tick(1);
        chk("mib_start", 32'(bus.o_mib_start), 32'd1);
        chk("mib_addr", 32'(bus.o_mib_addr), 32'h350010);
        chk("mib_rdwr", 32'(bus.o_mib_rd_wr_n), 32'd1);
        chk("mib_no_cmd", 32'(bus.o_cmd_sel), 32'd0);
        bus.i_mib_ack     = 1'b1;
        bus.i_mib_rd_data = 32'h12345678;
        tick(1);
        bus.i_mib_ack     = 1'b0;
        bus.i_mib_rd_data = 32'h0;
        chk("mib_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
        chk("mib_rsp_seq", bus.o_rsp_seq, 32'd3);
        chk("mib_rsp_msg", 32'(bus.o_rsp_msg_id), 32'hF0);
        chk("mib_rsp_data", bus.o_rsp_data, 32'h12345678);
        tick(1);

        // MIB timeout, then a late ack
        send(32'd4, 8'h01, 32'h0100_0040, 32'h0);
        tick(1);
        tick(31);
        chk("mto_early", 32'(bus.o_rsp_valid), 32'd0);
        tick(1);
        chk("mto_valid", 32'(bus.o_rsp_valid), 32'd1);
        chk("mto_msg", 32'(bus.o_rsp_msg_id), 32'hF1);
        chk("mto_data", bus.o_rsp_data, 32'd0);
        chk("mto_seq", bus.o_rsp_seq, 32'd4);
        chk("mto_count", 32'(bus.o_timeout_cnt), 32'd1);
        tick(1);
        bus.i_mib_ack     = 1'b1;
        bus.i_mib_rd_data = 32'hAAAA5555;
        tick(3);
        bus.i_mib_ack     = 1'b0;
        bus.i_mib_rd_data = 32'h0;
        chk("late_ack_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("late_ack_count", 32'(bus.o_timeout_cnt), 32'd1);
        chk("late_ack_ready", 32'(bus.o_req_ready), 32'd1);

        // bad msg_id, then unmapped select
        send(32'd5, 8'h07, 32'h0000_0100, 32'h0);
        tick(1);
        chk("bad_msg_valid", 32'(bus.o_rsp_valid), 32'd1);
        chk("bad_msg_msg", 32'(bus.o_rsp_msg_id), 32'hFF);
        chk("bad_msg_data", bus.o_rsp_data, 32'd0);
        chk("bad_msg_nobus", 32'({bus.o_cmd_sel, bus.o_mib_start}), 32'd0);
        tick(1);
        send(32'd6, 8'h00, 32'h0200_0000, 32'h5);
        tick(1);
        chk("bad_sel_valid", 32'(bus.o_rsp_valid), 32'd1);
        chk("bad_sel_msg", 32'(bus.o_rsp_msg_id), 32'hF1);
        chk("bad_sel_seq", bus.o_rsp_seq, 32'd6);
        chk("bad_sel_nobus", 32'({bus.o_cmd_sel, bus.o_mib_start}), 32'd0);
        chk("bad_sel_count", 32'(bus.o_timeout_cnt), 32'd1);
        tick(1);

        // response back-pressure on a command-bus read
        bus.i_rsp_ready = 1'b0;
        send(32'd7, 8'h01, 32'h0000_0ABC, 32'h0);
        tick(1);
        chk("bp_cmd_addr", 32'(bus.o_cmd_addr), 32'h00ABC);
        chk("bp_cmd_rdwr", 32'(bus.o_cmd_rd_wr_n), 32'd1);
        bus.i_cmd_ack     = 1'b1;
        bus.i_cmd_rd_data = 32'hCAFEF00D;
        tick(1);
        bus.i_cmd_ack     = 1'b0;
        bus.i_cmd_rd_data = 32'h0;
        chk("bp_rsp_data", bus.o_rsp_data, 32'hCAFEF00D);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            ok = bus.o_rsp_valid === 1'b1 && bus.o_rsp_seq === 32'd7 &&
                 bus.o_rsp_msg_id === 8'hF0 &&
                 bus.o_rsp_data === 32'hCAFEF00D &&
                 bus.o_req_ready === 1'b0;
            chk("bp_hold", 32'(ok), 32'd1);
        end
        bus.i_rsp_ready = 1'b1;
        tick(1);
        chk("bp_release_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("bp_release_ready", 32'(bus.o_req_ready), 32'd1);

        // reset in the middle of a command-bus wait
        send(32'd8, 8'h00, 32'h0000_0200, 32'h55AA55AA);
        tick(2);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_ready", 32'(bus.o_req_ready), 32'd0);
        chk("mrst_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("mrst_cmd_addr", 32'(bus.o_cmd_addr), 32'd0);
        chk("mrst_cmd_data", bus.o_cmd_wr_data, 32'd0);
        chk("mrst_mib_addr", 32'(bus.o_mib_addr), 32'd0);
        chk("mrst_mib_rdwr", 32'(bus.o_mib_rd_wr_n), 32'd0);
        chk("mrst_rsp_seq", bus.o_rsp_seq, 32'd0);
        chk("mrst_rsp_msg", 32'(bus.o_rsp_msg_id), 32'd0);
        chk("mrst_rsp_data", bus.o_rsp_data, 32'd0);
        chk("mrst_count", 32'(bus.o_timeout_cnt), 32'd0);
        tick(1);
        rst_n = 1'b1;
        bus.i_cmd_ack = 1'b1;
        tick(1);
        chk("mrst_idle_ready", 32'(bus.o_req_ready), 32'd1);
        tick(3);
        bus.i_cmd_ack = 1'b0;
        chk("mrst_no_rsp", 32'(bus.o_rsp_valid), 32'd0);

        // ack on the same cycle the timeout would fire
        send(32'd9, 8'h00, 32'h0000_0300, 32'h1);
        tick(1);
        tick(15);
        chk("tie_early", 32'(bus.o_rsp_valid), 32'd0);
        bus.i_cmd_ack = 1'b1;
        tick(1);
        bus.i_cmd_ack = 1'b0;
        chk("tie_valid", 32'(bus.o_rsp_valid), 32'd1);
        chk("tie_msg", 32'(bus.o_rsp_msg_id), 32'hF0);
        chk("tie_count", 32'(bus.o_timeout_cnt), 32'd0);
        tick(1);

        // command-bus timeout
        send(32'd10, 8'h00, 32'h0000_0400, 32'h2);
        tick(1);
        tick(15);
        chk("cto_early", 32'(bus.o_rsp_valid), 32'd0);
        tick(1);
        chk("cto_msg", 32'(bus.o_rsp_msg_id), 32'hF1);
        chk("cto_count", 32'(bus.o_timeout_cnt), 32'd1);
        tick(1);

        // saturation: preload near the top, then force timeouts
        force dut.timeout_cnt = 16'hFFFD;
        #1 release dut.timeout_cnt;
        chk("sat_preload", 32'(bus.o_timeout_cnt), 32'hFFFD);
        for (int k = 0; k < 3; k++) begin
            send(32'(11 + k), 8'h00, 32'h0000_0500, 32'h3);
            tick(17);
            chk("sat_msg", 32'(bus.o_rsp_msg_id), 32'hF1);
            chk("sat_count", 32'(bus.o_timeout_cnt), 32'(exp_sat[k]));
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
